audio_post: RTL and testbench
=============================

# audio_post

Stereo audio post-processing stage between the Amiga chipset audio outputs (15-bit signed `ldata`/`rdata`, `clk_28` domain) and the 16-bit signed `AUDIO_L`/`AUDIO_R` framework outputs. The block decimates to a fixed sample rate, applies optional stereo crossmix, digital gain with saturation, and a one-pole low-pass filter. Results are registered and accompanied by a one-cycle output strobe. The block replaces the plain `{ldata,1'b0}` assignment in `emu`.

## Interface
- `CE_DIV`, 600: clocks per output sample (28.6875 MHz / 600 ≈ 47.8 kHz); legal range 8..4095.
- `FLT_SHIFT`, 3: low-pass coefficient as a power of two, α = 2^-FLT_SHIFT; legal range 1..6.

- `clk` in 1: 28.6875 MHz system clock (`clk_28`).
- `_rst` in 1: asynchronous, active-low reset.
- `ldata` in 15: left chipset sample, signed.
- `rdata` in 15: right chipset sample, signed.
- `mix` in 2: crossmix amount; 0 none, 1 1/8, 2 1/4, 3 1/2 (mono).
- `vol` in 2: gain, left shift by 0..3 (+0/+6/+12/+18 dB).
- `flt_en` in 1: low-pass enable.
- `audio_l` out 16: left output, signed.
- `audio_r` out 16: right output, signed.
- `smp_ce` out 1: one-cycle pulse when the outputs update.
- `busy` out 1: high while the FSM is outside IDLE.

## Operation
- A divider counts 0..CE_DIV-1. The tick occurs at count 0. On the tick in IDLE, the block captures `ldata`, `rdata`, `mix`, `vol` and `flt_en`. Changes to these inputs between ticks have no effect on a conversion in progress.
- FSM states:
  - IDLE: go to MIX on tick.
  - MIX: go to GAIN.
  - GAIN: go to FILT.
  - FILT: go to OUT.
  - OUT: go to IDLE.
  - No other transitions.
- Capture: xL = {ldata,1'b0} and xR = {rdata,1'b0}, both sign-extended to 18 bits.
- MIX: with s = 3,2,1 for mix = 1,2,3:
  - mL = xL − ((xL − xR) >>> s)
  - mR = xR − ((xR − xL) >>> s)
  - mix = 0 passes values through. Arithmetic shift rounds toward −∞.
- GAIN: g = m <<< vol, computed in 21 bits, then saturated to 16 bits [−32768, 32767].
- FILT, per channel, with 16+FLT_SHIFT+1-bit signed accumulator `acc`:
  - When `flt_en` is captured high: acc ← acc + g − (acc >>> FLT_SHIFT), and y = acc >>> FLT_SHIFT.
  - When low: acc ← g <<< FLT_SHIFT, and y = g. This keeps re-enable glitch-free.
- OUT: `audio_l` ← yL and `audio_r` ← yR. `smp_ce` is high for exactly this one cycle.
- Reset values:
  - `audio_l` = `audio_r` = 0, `smp_ce` = 0, `busy` = 0.
  - acc = 0, divider = 0, FSM in IDLE.
- Reset mid-conversion: outputs clear immediately, and no `smp_ce` is emitted for the aborted sample.

## Timing
- Tick at edge t (inputs sampled). MIX, GAIN and FILT register at t+1..t+3. Outputs and `smp_ce` go valid after edge t+4.
- Fixed latency is 4 clocks. `busy` is high for 4 cycles per sample.
- CE_DIV ≥ 8 guarantees a tick never arrives while busy. A tick that does arrive outside IDLE is ignored.
- The first tick occurs on the first clock after `_rst` deasserts.

## Configuration
- `AUDIO_POST_MIX_EN` defined: MIX stage implemented as above.
- Undefined: the `mix` input is ignored and mL = xL, mR = xR. The MIX state still exists, so latency stays 4 clocks.

## Structure
- Package `audio_post_pkg` holds:
  - FSM state enum (IDLE, MIX, GAIN, FILT, OUT).
  - Mix code constants.
  - Width localparams: 18-bit mix width, 21-bit gain width, accumulator width function of FLT_SHIFT.
  - Saturation function.
- Sub-module `audio_post_ch`: per-channel GAIN/saturate/FILT datapath with its own accumulator, instantiated twice. Divider, capture, MIX and FSM stay in the top.

## Test plan
- Passthrough: mix=0, vol=0, flt_en=0, ldata=15'h1234, rdata=15'h7FFF → `audio_l`=16'h2468, `audio_r`=16'hFFFE, `smp_ce` 4 clocks after tick.
- Saturation: vol=3, ldata=15'h3000, rdata=15'h4000 → `audio_l`=16'h7FFF, `audio_r`=16'h8000.
- Crossmix (macro defined): mix=2, ldata=15'h0200, rdata=0 → `audio_l`=16'h0300, `audio_r`=16'h0100.
  - mix=3, ldata=15'h0100, rdata=15'h0300 → both 16'h0400.
  - Macro undefined, same stimulus → 16'h0200 / 16'h0600.
- Filter step: FLT_SHIFT=3, flt_en=1, acc=0, ldata steps to 15'h2000 → `audio_l` = 16'h0800, then 16'h0F00, monotonic toward 16'h4000. Toggling flt_en 0→1 at steady input gives no output jump.
- Rate: CE_DIV=600 → `smp_ce` period exactly 600 clocks.
- Reset: assert `_rst` during FILT → all outputs 0 asynchronously, no `smp_ce`. After release, the first `smp_ce` follows 4 clocks after the first tick, and the filter restarts from acc=0.

Source files
------------

// File: rtl/audio_post_pkg.sv
// audio_post_pkg: shared FSM states, mix codes, datapath widths and saturation helper.
package audio_post_pkg;
  typedef enum logic [2:0] {IDLE, MIX, GAIN, FILT, OUT} state_t;
  localparam logic [1:0] MIX_NONE = 2'd0, MIX_8 = 2'd1, MIX_4 = 2'd2, MIX_MONO = 2'd3;
  localparam int MIX_W = 18;
  localparam int GAIN_W = 21;
  function automatic int acc_w(input int s);
    return 16 + s + 1;
  endfunction
  function automatic logic signed [15:0] sat16(input logic signed [GAIN_W-1:0] v);
    return v > 21'sd32767 ? 16'sh7fff : v < -21'sd32768 ? 16'sh8000 : v[15:0];
  endfunction
endpackage

// File: rtl/audio_post_if.sv
// audio_post_if: chipset sample inputs, controls and processed stereo outputs.
interface audio_post_if;
  logic signed [14:0] ldata, rdata;
  logic [1:0] mix, vol;
  logic flt_en;
  logic signed [15:0] audio_l, audio_r;
  logic smp_ce, busy;
  modport master (output ldata, rdata, mix, vol, flt_en, input audio_l, audio_r, smp_ce, busy);
  modport slave (input ldata, rdata, mix, vol, flt_en, output audio_l, audio_r, smp_ce, busy);
endinterface

// File: rtl/audio_post_ch.sv
// audio_post_ch: per-channel gain, saturation and one-pole low-pass with its own accumulator.
module audio_post_ch import audio_post_pkg::*; #(
  parameter int FLT_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    _rst,
  input  logic                    ld_g,
  input  logic                    ld_f,
  input  logic signed [MIX_W-1:0] m,
  input  logic [1:0]              vol,
  input  logic                    flt_en,
  output logic signed [15:0]      y
);
  localparam int AW = acc_w(FLT_SHIFT);
  logic signed [15:0] g;
  logic signed [AW-1:0] acc, ge, an;
  assign ge = AW'(g);
  // bypass preloads acc with g scaled up so re-enabling starts at steady state
  assign an = flt_en ? acc + ge - (acc >>> FLT_SHIFT) : ge <<< FLT_SHIFT;
  assign y = 16'(acc >>> FLT_SHIFT);
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      g <= '0;
      acc <= '0;
    end else begin
      if (ld_g) g <= sat16(GAIN_W'(m) <<< vol);
      if (ld_f) acc <= an;
    end
endmodule

// File: rtl/audio_post.sv
// audio_post: decimating stereo post-processor (capture, crossmix, gain, low-pass, output strobe).
// Crossmix is built only when AUDIO_POST_MIX_EN is defined; otherwise mix is ignored.
module audio_post import audio_post_pkg::*; #(
  parameter int CE_DIV = 600,
  parameter int FLT_SHIFT = 3
) (
  input logic clk,
  input logic _rst,
  audio_post_if.slave bus
);
  state_t state;
  logic [11:0] cnt;
  logic tick;
  logic signed [MIX_W-1:0] xl, xr, ml, mr, mlc, mrc;
  logic [1:0] vol_q;
  logic en_q;
  logic signed [15:0] yl, yr;
  assign tick = cnt == '0;
`ifdef AUDIO_POST_MIX_EN
  logic [1:0] mix_q, s;
  assign s = mix_q == MIX_8 ? 2'd3 : mix_q == MIX_4 ? 2'd2 : 2'd1;
  assign mlc = mix_q == MIX_NONE ? xl : xl - ((xl - xr) >>> s);
  assign mrc = mix_q == MIX_NONE ? xr : xr - ((xr - xl) >>> s);
`else
  assign mlc = xl;
  assign mrc = xr;
`endif
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) cnt <= '0;
    else cnt <= cnt == 12'(CE_DIV - 1) ? '0 : cnt + 12'd1;
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      state <= IDLE;
      xl <= '0;
      xr <= '0;
      ml <= '0;
      mr <= '0;
      vol_q <= '0;
      en_q <= 1'b0;
`ifdef AUDIO_POST_MIX_EN
      mix_q <= '0;
`endif
      bus.audio_l <= '0;
      bus.audio_r <= '0;
      bus.smp_ce <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.smp_ce <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          xl <= MIX_W'($signed({bus.ldata, 1'b0}));
          xr <= MIX_W'($signed({bus.rdata, 1'b0}));
          vol_q <= bus.vol;
          en_q <= bus.flt_en;
`ifdef AUDIO_POST_MIX_EN
          mix_q <= bus.mix;
`endif
          bus.busy <= 1'b1;
          state <= MIX;
        end
        MIX: begin
          ml <= mlc;
          mr <= mrc;
          state <= GAIN;
        end
        GAIN: state <= FILT;
        FILT: state <= OUT;
        OUT: begin
          bus.audio_l <= yl;
          bus.audio_r <= yr;
          bus.smp_ce <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  audio_post_ch #(.FLT_SHIFT(FLT_SHIFT)) u_l (
    .clk(clk), ._rst(_rst), .ld_g(state == GAIN), .ld_f(state == FILT),
    .m(ml), .vol(vol_q), .flt_en(en_q), .y(yl)
  );
  audio_post_ch #(.FLT_SHIFT(FLT_SHIFT)) u_r (
    .clk(clk), ._rst(_rst), .ld_g(state == GAIN), .ld_f(state == FILT),
    .m(mr), .vol(vol_q), .flt_en(en_q), .y(yr)
  );
endmodule

// File: tb/tb_audio_post.sv
// tb_audio_post: randomized self-checking bench with an arithmetic reference model of audio_post.
module tb_audio_post;
  localparam int CE = 600;
  localparam int FS = 3;
  localparam int K = 1 << FS;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, last_ce = 0, checks = 0, failures = 0, acc_l = 0, acc_r = 0;
  logic signed [15:0] prev_l;
  audio_post_if bus();
  audio_post #(.CE_DIV(CE), .FLT_SHIFT(FS)) dut (.clk(clk), ._rst(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int fdiv(input int x, input int k);
    return x >= 0 ? x / k : -((-x + k - 1) / k);
  endfunction
`ifdef AUDIO_POST_MIX_EN
  function automatic int mixv(input int a, input int b, input int m);
    return m == 0 ? a : a - fdiv(a - b, 1 << (4 - m));
  endfunction
`endif
  function automatic int gain(input int m, input int v);
    int g;
    g = m * (1 << v);
    return g > 32767 ? 32767 : g < -32768 ? -32768 : g;
  endfunction

  task automatic run(input int l, input int r, input int mx, input int vl, input bit en,
                     input int gap, input string nm);
    int xl, xr, ml, mr, gl, gr, yl, yr, nb;
    bit got;
    bus.ldata = 15'(l);
    bus.rdata = 15'(r);
    bus.mix = 2'(mx);
    bus.vol = 2'(vl);
    bus.flt_en = en;
    xl = 2 * int'(bus.ldata);
    xr = 2 * int'(bus.rdata);
`ifdef AUDIO_POST_MIX_EN
    ml = mixv(xl, xr, mx);
    mr = mixv(xr, xl, mx);
`else
    ml = xl;
    mr = xr;
`endif
    gl = gain(ml, vl);
    gr = gain(mr, vl);
    acc_l = en ? acc_l + gl - fdiv(acc_l, K) : gl * K;
    acc_r = en ? acc_r + gr - fdiv(acc_r, K) : gr * K;
    yl = fdiv(acc_l, K);
    yr = fdiv(acc_r, K);
    nb = 0;
    got = 0;
    for (int i = 0; i < CE + 100 && !got; i++) begin
      @(negedge clk);
      if (bus.smp_ce) got = 1;
      else if (bus.busy) begin
        nb++;
        bus.ldata = 15'($urandom);
        bus.rdata = 15'($urandom);
        bus.mix = 2'($urandom);
        bus.vol = 2'($urandom);
        bus.flt_en = 1'($urandom);
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: no smp_ce within %0d cycles", nm, CE + 100);
    end else begin
      checks++;
      if (cyc - last_ce != gap) begin
        failures++;
        $display("FAIL %s spacing: got %0d cycles, want %0d", nm, cyc - last_ce, gap);
      end
      checks++;
      if (nb != 4) begin
        failures++;
        $display("FAIL %s busy_len: got %0d, want 4", nm, nb);
      end
      checks++;
      if (bus.audio_l !== 16'(yl)) begin
        failures++;
        $display("FAIL %s audio_l: got %h, want %h", nm, bus.audio_l, 16'(yl));
      end
      checks++;
      if (bus.audio_r !== 16'(yr)) begin
        failures++;
        $display("FAIL %s audio_r: got %h, want %h", nm, bus.audio_r, 16'(yr));
      end
      last_ce = cyc;
      @(negedge clk);
      checks++;
      if (bus.smp_ce !== 1'b0) begin
        failures++;
        $display("FAIL %s smp_ce_width: got %b, want 0", nm, bus.smp_ce);
      end
    end
  endtask

  task automatic expect_lr(input logic [15:0] el, input logic [15:0] er, input string nm);
    checks++;
    if (bus.audio_l !== el) begin
      failures++;
      $display("FAIL %s const_l: got %h, want %h", nm, bus.audio_l, el);
    end
    checks++;
    if (bus.audio_r !== er) begin
      failures++;
      $display("FAIL %s const_r: got %h, want %h", nm, bus.audio_r, er);
    end
  endtask

  task automatic check_idle_zero(input string nm);
    checks++;
    if ({bus.audio_l, bus.audio_r, bus.smp_ce, bus.busy} !== 34'd0) begin
      failures++;
      $display("FAIL %s: got l=%h r=%h ce=%b busy=%b, want all 0", nm,
               bus.audio_l, bus.audio_r, bus.smp_ce, bus.busy);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    last_ce = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ldata = '0;
    bus.rdata = '0;
    bus.mix = '0;
    bus.vol = '0;
    bus.flt_en = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    release_rst();
  endtask

  task automatic test_passthrough();
    run('h1234, 'h7FFF, 0, 0, 0, 5, "passthrough");
    expect_lr(16'h2468, 16'hFFFE, "passthrough");
  endtask

  task automatic test_saturation();
    run('h3000, 'h4000, 0, 3, 0, CE, "saturation");
    expect_lr(16'h7FFF, 16'h8000, "saturation");
  endtask

  task automatic test_mix();
    run('h0200, 0, 2, 0, 0, CE, "mix2");
`ifdef AUDIO_POST_MIX_EN
    expect_lr(16'h0300, 16'h0100, "mix2");
`else
    expect_lr(16'h0400, 16'h0000, "mix2");
`endif
    run('h0100, 'h0300, 3, 0, 0, CE, "mix3");
`ifdef AUDIO_POST_MIX_EN
    expect_lr(16'h0400, 16'h0400, "mix3");
`else
    expect_lr(16'h0200, 16'h0600, "mix3");
`endif
  endtask

  task automatic test_filter();
    run(0, 0, 0, 0, 0, CE, "flt_zero");
    run('h2000, 0, 0, 0, 1, CE, "flt_step1");
    expect_lr(16'h0800, 16'h0000, "flt_step1");
    run('h2000, 0, 0, 0, 1, CE, "flt_step2");
    expect_lr(16'h0F00, 16'h0000, "flt_step2");
    prev_l = bus.audio_l;
    for (int i = 0; i < 6; i++) begin
      run('h2000, 0, 0, 0, 1, CE, "flt_rise");
      checks++;
      if (!(bus.audio_l > prev_l && bus.audio_l <= 16'sh4000)) begin
        failures++;
        $display("FAIL flt_monotonic: got %h after %h, want rising up to 4000", bus.audio_l, prev_l);
      end
      prev_l = bus.audio_l;
    end
    run('h1000, 0, 0, 0, 0, CE, "flt_bypass");
    run('h1000, 0, 0, 0, 1, CE, "flt_reenable");
    expect_lr(16'h2000, 16'h0000, "flt_reenable");
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++)
      run(int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), CE, "random");
  endtask

  task automatic test_reset_mid();
    bit seen;
    run('h1234, 'h7FFF, 0, 0, 0, CE, "pre_abort");
    bus.flt_en = 1'b1;
    seen = 0;
    for (int i = 0; i < CE + 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.busy;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL abort_busy timeout: busy never rose");
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("abort_async_clear");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_zero("abort_hold");
    end
    acc_l = 0;
    acc_r = 0;
    release_rst();
    run('h2000, 0, 0, 0, 1, 5, "restart");
    expect_lr(16'h0800, 16'h0000, "restart");
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturation();
    test_mix();
    test_filter();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
